// File: rtl/dm_dma_arbiter_if.sv
// rtl/dm_dma_arbiter_if.sv - M-stage, DMA control and data-memory signals shared by the arbiter
interface dm_dma_arbiter_if #(
  parameter int LEN_WIDTH = 16
);
  logic                 cpu_req;
  logic [31:0]          cpu_addr;
  logic [31:0]          cpu_wdata;
  logic [3:0]           cpu_byteen;
  logic [31:0]          cpu_rdata;

  logic                 dma_start;
  logic [31:0]          dma_src;
  logic [31:0]          dma_dst;
  logic [LEN_WIDTH-1:0] dma_len;
  logic                 dma_busy;
  logic                 dma_done;
  logic [LEN_WIDTH-1:0] dma_remaining;

  logic [31:0]          mem_addr;
  logic [31:0]          mem_wdata;
  logic [3:0]           mem_byteen;
  logic [31:0]          mem_rdata;

  modport slave (
    input  cpu_req, cpu_addr, cpu_wdata, cpu_byteen,
    output cpu_rdata,
    input  dma_start, dma_src, dma_dst, dma_len,
    output dma_busy, dma_done, dma_remaining,
    output mem_addr, mem_wdata, mem_byteen,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_addr, cpu_wdata, cpu_byteen,
    input  cpu_rdata,
    output dma_start, dma_src, dma_dst, dma_len,
    input  dma_busy, dma_done, dma_remaining,
    input  mem_addr, mem_wdata, mem_byteen,
    output mem_rdata
  );
endinterface

// File: rtl/dm_dma_arbiter.sv
// rtl/dm_dma_arbiter.sv - data-memory port arbiter: M stage has zero-wait priority, word-copy DMA uses idle cycles
module dm_dma_arbiter #(
  parameter int LEN_WIDTH = 16
) (
  input  logic clk,
  input  logic reset,
  dm_dma_arbiter_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [31:0]          src_q, src_d;
  logic [31:0]          dst_q, dst_d;
  logic [31:0]          buf_q, buf_d;
  logic [LEN_WIDTH-1:0] rem_q, rem_d;
  logic                 dma_own;

  // Any M-stage access steals the cycle; the DMA simply holds its state.
  assign dma_own = !bus.cpu_req && (state_q == S_RD || state_q == S_WR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      buf_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      buf_q   <= buf_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    buf_d   = buf_q;
    rem_d   = rem_q;
    case (state_q)
      S_IDLE: begin
        if (bus.dma_start) begin
          src_d   = {bus.dma_src[31:2], 2'b00};
          dst_d   = {bus.dma_dst[31:2], 2'b00};
          rem_d   = bus.dma_len;
          state_d = (bus.dma_len != '0) ? S_RD : S_DONE;
        end
      end
      S_RD: begin
        if (dma_own) begin
          buf_d   = bus.mem_rdata;
          state_d = S_WR;
        end
      end
      S_WR: begin
        if (dma_own) begin
          src_d = src_q + 32'd4;
          dst_d = dst_q + 32'd4;
          if (rem_q != '0) begin
            rem_d = rem_q - LEN_WIDTH'(1);
          end
          state_d = (rem_q <= LEN_WIDTH'(1)) ? S_DONE : S_RD;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.mem_addr   = bus.cpu_addr;
    bus.mem_wdata  = bus.cpu_wdata;
    bus.mem_byteen = bus.cpu_byteen;
    if (dma_own) begin
      if (state_q == S_RD) begin
        bus.mem_addr   = src_q;
        bus.mem_byteen = 4'b0000;
      end else begin
        bus.mem_addr   = dst_q;
        bus.mem_wdata  = buf_q;
        bus.mem_byteen = 4'b1111;
      end
    end
    // No store may reach memory while reset is held, whoever drives the address.
    if (reset) begin
      bus.mem_byteen = 4'b0000;
    end
  end

  assign bus.cpu_rdata     = bus.mem_rdata;
  assign bus.dma_busy      = (state_q != S_IDLE);
  assign bus.dma_done      = (state_q == S_DONE);
  assign bus.dma_remaining = rem_q;

endmodule

// File: tb/tb_dm_dma_arbiter.sv
// tb/tb_dm_dma_arbiter.sv - directed self-checking bench for dm_dma_arbiter
module tb_dm_dma_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dm_dma_arbiter_if #(.LEN_WIDTH(16)) bus ();

  dm_dma_arbiter #(.LEN_WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] mem [0:1023];
  logic        mem_init;
  logic        bd_we;
  logic [9:0]  bd_idx;
  logic [31:0] bd_data;
  int          n_assert = 0;
  int          n_fail   = 0;

  assign bus.mem_rdata = mem[bus.mem_addr[11:2]];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'hDEAD0000 | 32'(i);
    end else if (bd_we) begin
      mem[bd_idx] <= bd_data;
    end else begin
      for (int b = 0; b < 4; b++)
        if (bus.mem_byteen[b]) mem[bus.mem_addr[11:2]][b*8 +: 8] <= bus.mem_wdata[b*8 +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [9:0] idx, input logic [31:0] data);
    bd_we   = 1'b1;
    bd_idx  = idx;
    bd_data = data;
    tick();
    bd_we   = 1'b0;
  endtask

  task automatic start(input logic [31:0] src, input logic [31:0] dst, input logic [15:0] len);
    bus.dma_start = 1'b1;
    bus.dma_src   = src;
    bus.dma_dst   = dst;
    bus.dma_len   = len;
    tick();
    bus.dma_start = 1'b0;
  endtask

  // Checks the outputs of the current cycle, then advances to the next one.
  task automatic cyc(input string tag, input logic busy, input logic done, input logic [15:0] rem,
                     input logic [3:0] be, input logic [31:0] addr, input logic [31:0] wd, input bit chk_wd);
    #1;
    chk({tag, " busy"},   32'(bus.dma_busy),      32'(busy));
    chk({tag, " done"},   32'(bus.dma_done),      32'(done));
    chk({tag, " rem"},    32'(bus.dma_remaining), 32'(rem));
    chk({tag, " byteen"}, 32'(bus.mem_byteen),    32'(be));
    chk({tag, " addr"},   bus.mem_addr,           addr);
    if (chk_wd) chk({tag, " wdata"}, bus.mem_wdata, wd);
    tick();
  endtask

  initial begin
    reset          = 1'b1;
    mem_init       = 1'b1;
    bd_we          = 1'b0;
    bd_idx         = '0;
    bd_data        = '0;
    bus.cpu_req    = 1'b0;
    bus.cpu_addr   = 32'h20;
    bus.cpu_wdata  = 32'h0;
    bus.cpu_byteen = 4'b1111;
    bus.dma_start  = 1'b0;
    bus.dma_src    = '0;
    bus.dma_dst    = '0;
    bus.dma_len    = '0;
    tick();
    mem_init = 1'b0;
    #1;
    chk("reset busy",   32'(bus.dma_busy),      32'd0);
    chk("reset done",   32'(bus.dma_done),      32'd0);
    chk("reset rem",    32'(bus.dma_remaining), 32'd0);
    chk("reset byteen", 32'(bus.mem_byteen),    32'd0);
    chk("reset addr",   bus.mem_addr,           32'h20);
    bus.cpu_addr   = 32'h0;
    bus.cpu_byteen = 4'b0000;
    poke(10'd64, 32'd1);
    poke(10'd65, 32'd2);
    poke(10'd66, 32'd3);
    reset = 1'b0;
    tick();

    // Idle passthrough
    bus.cpu_req    = 1'b1;
    bus.cpu_addr   = 32'h10;
    bus.cpu_byteen = 4'b0011;
    bus.cpu_wdata  = 32'hAABBCCDD;
    #1;
    chk("pass addr",   bus.mem_addr,          32'h10);
    chk("pass wdata",  bus.mem_wdata,         32'hAABBCCDD);
    chk("pass byteen", 32'(bus.mem_byteen),   32'h3);
    chk("pass busy",   32'(bus.dma_busy),     32'd0);
    chk("pass rdata",  bus.cpu_rdata,         32'hDEAD0004);
    tick();
    chk("pass store", mem[4], 32'hDEADCCDD);
    bus.cpu_req    = 1'b0;
    bus.cpu_addr   = 32'h0;
    bus.cpu_byteen = 4'b0000;
    bus.cpu_wdata  = 32'h0;

    // Quiet 3-word copy
    start(32'h100, 32'h200, 16'd3);
    for (int k = 1; k <= 6; k++) begin
      if (k % 2 == 1)
        cyc($sformatf("quiet rd%0d", k), 1'b1, 1'b0, 16'(3 - (k - 1) / 2), 4'b0000,
            32'h100 + 32'(4 * ((k - 1) / 2)), 32'h0, 1'b0);
      else
        cyc($sformatf("quiet wr%0d", k), 1'b1, 1'b0, 16'(3 - (k - 1) / 2), 4'b1111,
            32'h200 + 32'(4 * (k / 2 - 1)), 32'(k / 2), 1'b1);
    end
    cyc("quiet done", 1'b1, 1'b1, 16'd0, 4'b0000, 32'h0, 32'h0, 1'b0);
    cyc("quiet idle", 1'b0, 1'b0, 16'd0, 4'b0000, 32'h0, 32'h0, 1'b0);
    chk("quiet mem0", mem[128], 32'd1);
    chk("quiet mem1", mem[129], 32'd2);
    chk("quiet mem2", mem[130], 32'd3);

    // CPU interference in t+2, t+3
    start(32'h100, 32'h240, 16'd3);
    cyc("intf rd1", 1'b1, 1'b0, 16'd3, 4'b0000, 32'h100, 32'h0, 1'b0);
    bus.cpu_req    = 1'b1;
    bus.cpu_addr   = 32'h40;
    bus.cpu_byteen = 4'b0100;
    bus.cpu_wdata  = 32'h11223344;
    cyc("intf cpu st", 1'b1, 1'b0, 16'd3, 4'b0100, 32'h40, 32'h11223344, 1'b1);
    bus.cpu_addr   = 32'h44;
    bus.cpu_byteen = 4'b0000;
    #1;
    chk("intf cpu rdata", bus.cpu_rdata, 32'hDEAD0011);
    cyc("intf cpu ld", 1'b1, 1'b0, 16'd3, 4'b0000, 32'h44, 32'h11223344, 1'b1);
    bus.cpu_req   = 1'b0;
    bus.cpu_addr  = 32'h0;
    bus.cpu_wdata = 32'h0;
    cyc("intf wr1", 1'b1, 1'b0, 16'd3, 4'b1111, 32'h240, 32'd1, 1'b1);
    cyc("intf rd2", 1'b1, 1'b0, 16'd2, 4'b0000, 32'h104, 32'h0, 1'b0);
    cyc("intf wr2", 1'b1, 1'b0, 16'd2, 4'b1111, 32'h244, 32'd2, 1'b1);
    cyc("intf rd3", 1'b1, 1'b0, 16'd1, 4'b0000, 32'h108, 32'h0, 1'b0);
    cyc("intf wr3", 1'b1, 1'b0, 16'd1, 4'b1111, 32'h248, 32'd3, 1'b1);
    cyc("intf done", 1'b1, 1'b1, 16'd0, 4'b0000, 32'h0, 32'h0, 1'b0);
    cyc("intf idle", 1'b0, 1'b0, 16'd0, 4'b0000, 32'h0, 32'h0, 1'b0);
    chk("intf mem0", mem[144], 32'd1);
    chk("intf mem1", mem[145], 32'd2);
    chk("intf mem2", mem[146], 32'd3);
    chk("intf cpu mem", mem[16], 32'hDE220010);

    // Zero-length transfer
    start(32'h500, 32'h600, 16'd0);
    cyc("len0 done", 1'b1, 1'b1, 16'd0, 4'b0000, 32'h0, 32'h0, 1'b0);
    cyc("len0 idle", 1'b0, 1'b0, 16'd0, 4'b0000, 32'h0, 32'h0, 1'b0);
    chk("len0 dst untouched", mem[384], 32'hDEAD0180);

    // Misaligned source address
    start(32'h103, 32'h300, 16'd1);
    cyc("mis rd", 1'b1, 1'b0, 16'd1, 4'b0000, 32'h100, 32'h0, 1'b0);
    cyc("mis wr", 1'b1, 1'b0, 16'd1, 4'b1111, 32'h300, 32'd1, 1'b1);
    cyc("mis done", 1'b1, 1'b1, 16'd0, 4'b0000, 32'h0, 32'h0, 1'b0);
    chk("mis mem", mem[192], 32'd1);

    // Destination wraps past 0xFFFFFFFC
    start(32'h100, 32'hFFFFFFFC, 16'd2);
    cyc("wrap rd1", 1'b1, 1'b0, 16'd2, 4'b0000, 32'h100, 32'h0, 1'b0);
    cyc("wrap wr1", 1'b1, 1'b0, 16'd2, 4'b1111, 32'hFFFFFFFC, 32'd1, 1'b1);
    cyc("wrap rd2", 1'b1, 1'b0, 16'd1, 4'b0000, 32'h104, 32'h0, 1'b0);
    cyc("wrap wr2", 1'b1, 1'b0, 16'd1, 4'b1111, 32'h0, 32'd2, 1'b1);
    cyc("wrap done", 1'b1, 1'b1, 16'd0, 4'b0000, 32'h0, 32'h0, 1'b0);
    chk("wrap mem hi", mem[1023], 32'd1);
    chk("wrap mem lo", mem[0], 32'd2);

    // Start pulsed during WR is ignored
    start(32'h100, 32'h280, 16'd2);
    cyc("ign rd1", 1'b1, 1'b0, 16'd2, 4'b0000, 32'h100, 32'h0, 1'b0);
    bus.dma_start = 1'b1;
    bus.dma_src   = 32'h140;
    bus.dma_dst   = 32'h380;
    bus.dma_len   = 16'd5;
    cyc("ign wr1", 1'b1, 1'b0, 16'd2, 4'b1111, 32'h280, 32'd1, 1'b1);
    bus.dma_start = 1'b0;
    cyc("ign rd2", 1'b1, 1'b0, 16'd1, 4'b0000, 32'h104, 32'h0, 1'b0);
    cyc("ign wr2", 1'b1, 1'b0, 16'd1, 4'b1111, 32'h284, 32'd2, 1'b1);
    cyc("ign done", 1'b1, 1'b1, 16'd0, 4'b0000, 32'h0, 32'h0, 1'b0);
    cyc("ign idle", 1'b0, 1'b0, 16'd0, 4'b0000, 32'h0, 32'h0, 1'b0);
    chk("ign mem0", mem[160], 32'd1);
    chk("ign mem1", mem[161], 32'd2);
    chk("ign other dst", mem[224], 32'hDEAD00E0);

    // Asynchronous reset in the middle of the second WR
    start(32'h100, 32'h400, 16'd3);
    cyc("rst rd1", 1'b1, 1'b0, 16'd3, 4'b0000, 32'h100, 32'h0, 1'b0);
    cyc("rst wr1", 1'b1, 1'b0, 16'd3, 4'b1111, 32'h400, 32'd1, 1'b1);
    cyc("rst rd2", 1'b1, 1'b0, 16'd2, 4'b0000, 32'h104, 32'h0, 1'b0);
    #1;
    chk("rst wr2 addr",   bus.mem_addr,        32'h404);
    chk("rst wr2 byteen", 32'(bus.mem_byteen), 32'hF);
    #1;
    reset = 1'b1;
    #1;
    chk("rst async busy",   32'(bus.dma_busy),      32'd0);
    chk("rst async done",   32'(bus.dma_done),      32'd0);
    chk("rst async rem",    32'(bus.dma_remaining), 32'd0);
    chk("rst async byteen", 32'(bus.mem_byteen),    32'd0);
    chk("rst async addr",   bus.mem_addr,           32'h0);
    tick();
    tick();
    chk("rst mem first", mem[256], 32'd1);
    chk("rst mem second", mem[257], 32'hDEAD0101);
    reset = 1'b0;
    cyc("rst idle1", 1'b0, 1'b0, 16'd0, 4'b0000, 32'h0, 32'h0, 1'b0);
    cyc("rst idle2", 1'b0, 1'b0, 16'd0, 4'b0000, 32'h0, 32'h0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
